div_result_serializer: RTL and testbench

Output stage of the byte-serial divider top. Accepts 65-bit results `{sign_mode, quotient[31:0], remainder[31:0]}` from the radix-2 SRT divider core into a 4-entry FIFO. Emits each result as an 8-byte frame on the top-level byte port.
- Remainder LSB goes out first; quotient MSB goes out last.
- `pull_out` marks the first byte of each frame.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_result_fifo.sv | 52 +++++
 rtl/div_result_serializer.sv | 123 ++++++++++++
 tb/tb_div_result_serializer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider output path: result layout and serializer states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package div_pkg;

  localparam int DATA_WIDTH       = 65;
  localparam int BYTES_PER_RESULT = 8;

  // Result word field offsets
  localparam int SIGN_BIT = 64;
  localparam int Q_LSB    = 32;
  localparam int R_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/div_result_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry visible combinationally on rd_data.
// Latency: a write is visible at the head on the cycle after the write edge (no bypass).
// Backpressure: writes while full and reads while empty are ignored; full/empty exported.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 4,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Same index with differing wrap bits means the writer lapped the reader
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO, discarding any stored entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage array; contents are meaningless until pointed to by a valid entry
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/div_result_serializer.sv
// Buffers divider results and emits each as an 8-byte frame, remainder LSB first, quotient MSB last.
// Latency: write into empty FIFO at edge N -> first byte (pull_out) registered at edge N+1; frame period 10 cycles.
// Backpressure: res_ready = FIFO not full (pre-edge state); writes while full are dropped and set sticky overflow.
module div_result_serializer
  import div_pkg::*;
#(
  parameter int DATA_WIDTH       = div_pkg::DATA_WIDTH,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic [7:0]            data_out_out,
  output logic                  pull_out,
  output logic                  sign_out,
  output logic                  overflow
);

  // byte_cnt reaching this value means all 8 bytes have been driven
  localparam logic [3:0] LAST_CNT = 4'(BYTES_PER_RESULT);

  logic                  full;
  logic                  empty;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  state_t      state, state_nxt;
  logic [3:0]  byte_cnt, cnt_nxt;
  logic [63:0] shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        pull_nxt;
  logic        sign_nxt;

  assign res_ready = !full;

  div_result_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (LOG_BUFFER_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (res_valid),
    .wr_data (res_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Next-state and next-output decode: pop in IDLE, stream bytes in SEND, then two quiet cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    shift_nxt = shift;
    data_nxt  = data_out_out;
    pull_nxt  = 1'b0;
    sign_nxt  = sign_out;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        data_nxt = 8'h00;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = {head[Q_LSB +: 32], head[R_LSB +: 32]};
          data_nxt  = head[R_LSB +: 8];
          pull_nxt  = 1'b1;
          sign_nxt  = head[SIGN_BIT];
          cnt_nxt   = 4'd1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (byte_cnt == LAST_CNT) begin
          // Last byte has been shown for one cycle; start the quiet gap
          data_nxt  = 8'h00;
          cnt_nxt   = 4'd0;
          state_nxt = GAP;
        end else begin
          data_nxt = shift[{byte_cnt[2:0], 3'b000} +: 8];
          cnt_nxt  = byte_cnt + 4'd1;
        end
      end
      GAP: begin
        data_nxt  = 8'h00;
        state_nxt = IDLE;
      end
      default: begin
        data_nxt  = 8'h00;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_cnt     <= 4'd0;
      shift        <= '0;
      data_out_out <= 8'h00;
      pull_out     <= 1'b0;
      sign_out     <= 1'b0;
    end else begin
      state        <= state_nxt;
      byte_cnt     <= cnt_nxt;
      shift        <= shift_nxt;
      data_out_out <= data_nxt;
      pull_out     <= pull_nxt;
      sign_out     <= sign_nxt;
    end
  end

  // Sticky flag for any write attempted while the FIFO is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (res_valid && full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_div_result_serializer.sv
// Self-checking bench for div_result_serializer: scoreboard of expected results vs captured frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [64:0] res_data = '0;
  logic        res_ready;
  logic [7:0]  data_out_out;
  logic        pull_out;
  logic        sign_out;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] word;
    logic        sign;
    bit          pull_ok;
    bit          sign_ok;
    int          start;
  } frame_t;

  frame_t      obs_q[$];
  logic [64:0] exp_q[$];
  frame_t      cur;
  int          cap_idx = 0;
  int          pull_cnt = 0;

  div_result_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .data_out_out (data_out_out),
    .pull_out     (pull_out),
    .sign_out     (sign_out),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: assembles 8 bytes starting at each pull_out into one observed record
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cap_idx = 0;
      end else begin
        if (pull_out) pull_cnt++;
        if (cap_idx == 0) begin
          if (pull_out) begin
            cur.word       = '0;
            cur.word[7:0]  = data_out_out;
            cur.sign       = sign_out;
            cur.pull_ok    = 1'b1;
            cur.sign_ok    = 1'b1;
            cur.start      = cyc;
            cap_idx        = 1;
          end
        end else begin
          cur.word[8*cap_idx +: 8] = data_out_out;
          if (pull_out) cur.pull_ok = 1'b0;
          if (sign_out !== cur.sign) cur.sign_ok = 1'b0;
          cap_idx++;
          if (cap_idx == 8) begin
            obs_q.push_back(cur);
            cap_idx = 0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got %0d frames pending", obs_q.size());
    $fatal(1, "watchdog");
  end

  // Drive one write on the next rising edge; call at or just after a falling edge
  task automatic do_write(input logic [64:0] d);
    res_valid = 1'b1;
    res_data  = d;
    @(negedge clk);
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 400) begin
      @(negedge clk);
      #2;
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    #1;
    n_cmp++; if (data_out_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", data_out_out); end
    n_cmp++; if (pull_out !== 1'b0) begin n_bad++; $display("FAIL reset_pull: got %b expected 0", pull_out); end
    n_cmp++; if (sign_out !== 1'b0) begin n_bad++; $display("FAIL reset_sign: got %b expected 0", sign_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", res_ready); end
    #2 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    logic [64:0] e;
    frame_t      f;
    int          w;
    bit          ok;
    e = {1'b0, 32'h12345678, 32'h9ABCDEF0};
    exp_q.push_back(e);
    w = cyc + 1;
    do_write(e);
    wait_frames(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d frames expected 1", obs_q.size()); end
    if (ok) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (f.word !== e[63:0]) begin n_bad++; $display("FAIL single_word: got %h expected %h", f.word, e[63:0]); end
      n_cmp++; if (f.word[7:0] !== 8'hF0) begin n_bad++; $display("FAIL single_first_byte: got %h expected f0", f.word[7:0]); end
      n_cmp++; if (f.word[63:56] !== 8'h12) begin n_bad++; $display("FAIL single_last_byte: got %h expected 12", f.word[63:56]); end
      n_cmp++; if (f.sign !== 1'b0 || !f.sign_ok) begin n_bad++; $display("FAIL single_sign: got %b const=%0d expected 0 const=1", f.sign, f.sign_ok); end
      n_cmp++; if (!f.pull_ok) begin n_bad++; $display("FAIL single_pull: got extra pull_out expected first byte only"); end
      n_cmp++; if (f.start !== w + 1) begin n_bad++; $display("FAIL single_latency: got edge %0d expected %0d", f.start, w + 1); end
      @(negedge clk); #1;
      n_cmp++; if (data_out_out !== 8'h00 || pull_out !== 1'b0) begin n_bad++; $display("FAIL single_gap: got %h/%b expected 00/0", data_out_out, pull_out); end
      @(negedge clk); #1;
      n_cmp++; if (data_out_out !== 8'h00 || pull_out !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %h/%b expected 00/0", data_out_out, pull_out); end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [64:0] e;
    e = {1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A};
    exp_q.push_back(e);
    do_write(e);
    idle(1);
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, res_ready); end
      e = {1'b1, 32'(i), 32'h0};
      exp_q.push_back(e);
      do_write(e);
    end
    #1;
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got %b expected 0", res_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [64:0] e;
    frame_t      f;
    int          prev;
    bit          ok;
    do_write({1'b1, 32'hFFFF0000, 32'h0000FEED});
    #1;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    wait_frames(5, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_timeout: got %0d frames expected 5", obs_q.size()); end
    prev = 0;
    for (int k = 0; k < 5 && ok; k++) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (f.word !== e[63:0]) begin n_bad++; $display("FAIL ovf_word_%0d: got %h expected %h", k, f.word, e[63:0]); end
      n_cmp++; if (f.sign !== e[64] || !f.sign_ok || !f.pull_ok) begin n_bad++; $display("FAIL ovf_flags_%0d: got sign %b const %0d pull %0d expected %b 1 1", k, f.sign, f.sign_ok, f.pull_ok, e[64]); end
      if (k > 0) begin
        n_cmp++; if (f.start - prev !== 10) begin n_bad++; $display("FAIL ovf_spacing_%0d: got %0d expected 10", k, f.start - prev); end
      end
      prev = f.start;
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL ovf_extra_frames: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    idle(3);
  endtask

  task automatic test_simultaneous();
    logic [64:0] e;
    frame_t      f;
    int          w;
    bit          ok;
    w = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      e = {1'b0, 32'hC0000000 + 32'(k), 32'(k + 1)};
      exp_q.push_back(e);
      do_write(e);
    end
    idle(w + 11 - (cyc + 1));
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready_pre: got %b expected 1", res_ready); end
    e = {1'b0, 32'hC0000004, 32'h5};
    exp_q.push_back(e);
    do_write(e);
    #1;
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL simul_occupancy3: got ready %b expected 1", res_ready); end
    e = {1'b0, 32'hC0000005, 32'h6};
    exp_q.push_back(e);
    do_write(e);
    #1;
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL simul_full: got ready %b expected 0", res_ready); end
    wait_frames(6, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL simul_timeout: got %0d frames expected 6", obs_q.size()); end
    for (int k = 0; k < 6 && ok; k++) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (f.word !== e[63:0]) begin n_bad++; $display("FAIL simul_word_%0d: got %h expected %h", k, f.word, e[63:0]); end
      n_cmp++; if (f.start !== w + 1 + 10 * k) begin n_bad++; $display("FAIL simul_start_%0d: got %0d expected %0d", k, f.start, w + 1 + 10 * k); end
    end
    idle(3);
  endtask

  task automatic test_reset_mid_frame();
    int pc;
    do_write({1'b1, 32'h11223344, 32'h55667788});
    do_write({1'b1, 32'h0BADF00D, 32'h1});
    do_write({1'b1, 32'h0DEADBEE, 32'h2});
    idle(3);
    #1;
    n_cmp++; if (data_out_out !== 8'h44 || pull_out !== 1'b0) begin n_bad++; $display("FAIL rst_byte4: got %h/%b expected 44/0", data_out_out, pull_out); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (data_out_out !== 8'h00 || pull_out !== 1'b0) begin n_bad++; $display("FAIL rst_async_out: got %h/%b expected 00/0", data_out_out, pull_out); end
    n_cmp++; if (sign_out !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL rst_async_flags: got sign %b ovf %b expected 0 0", sign_out, overflow); end
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_ready: got %b expected 1", res_ready); end
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    pc = pull_cnt;
    idle(30);
    n_cmp++; if (pull_cnt !== pc || obs_q.size() != 0) begin n_bad++; $display("FAIL rst_no_frames: got %0d pulls %0d frames expected 0 0", pull_cnt - pc, obs_q.size()); end
  endtask

  task automatic test_boundary();
    logic [64:0] e;
    frame_t      f;
    int          w;
    bit          ok;
    w = cyc + 1;
    e = {1'b0, 32'hFFFFFFFF, 32'h00000000};
    exp_q.push_back(e);
    do_write(e);
    e = {1'b0, 32'h00000000, 32'hFFFFFFFF};
    exp_q.push_back(e);
    do_write(e);
    wait_frames(2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bnd_timeout: got %0d frames expected 2", obs_q.size()); end
    for (int k = 0; k < 2 && ok; k++) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (f.word !== e[63:0]) begin n_bad++; $display("FAIL bnd_word_%0d: got %h expected %h", k, f.word, e[63:0]); end
      n_cmp++; if (f.start !== w + 1 + 10 * k || !f.pull_ok) begin n_bad++; $display("FAIL bnd_timing_%0d: got start %0d pull_ok %0d expected %0d 1", k, f.start, f.pull_ok, w + 1 + 10 * k); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_frame();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
